// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a small 8-bit register file: write with sub-address and auto-increment,
// read from the current pointer. Bus signals are oversampled on I2C_clk.
module i2c_slave_regs #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h20,
    parameter int unsigned NREG_LOG2  = 4
) (
    input  logic                 I2C_clk,
    input  logic                 RESET,
    input  logic                 I2C_SCLK,
    inout  wire                  I2C_SDATA,
    input  logic [NREG_LOG2-1:0] RD_ADDR,
    output logic [7:0]           RD_DATA,
    output logic                 WR_STROBE,
    output logic [NREG_LOG2-1:0] WR_ADDR,
    output logic [7:0]           WR_DATA,
    output logic                 BUSY
);
    localparam int unsigned NREG = 1 << NREG_LOG2;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t               state;
    logic                 scl_s1, scl_s2, scl_d;
    logic                 sda_s1, sda_s2, sda_d;
    logic                 sda_oe;
    logic                 rw;
    logic [3:0]           bit_cnt;
    logic [7:0]           shreg;
    logic [NREG_LOG2-1:0] ptr;
    logic [7:0]           regs [NREG];

    logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0] rx_byte;

    // Open-drain: only ever pull low
    assign I2C_SDATA = sda_oe ? 1'b0 : 1'bz;
    assign RD_DATA   = regs[RD_ADDR];

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge I2C_clk or negedge RESET) begin
        if (!RESET) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= I2C_SCLK;  scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= I2C_SDATA; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign last_bit  = (bit_cnt == 4'd7);

    always_ff @(posedge I2C_clk or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            BUSY      <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= 8'h00;
            rw        <= 1'b0;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else begin
            WR_STROBE <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                BUSY    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= DEV_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    DEV_ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state <= DEV_ACK;
                                BUSY  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= IGNORE;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                    // First falling edge starts the ACK pulse, the second ends it
                    DEV_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            bit_cnt <= 4'd0;
                            if (state == DEV_ACK && rw) begin
                                state  <= RDATA;
                                shreg  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                state  <= (state == DEV_ACK) ? SUB_ADDR : WDATA;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    SUB_ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            ptr   <= rx_byte[NREG_LOG2-1:0];
                            state <= SUB_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            regs[ptr] <= rx_byte;
                            WR_STROBE <= 1'b1;
                            WR_ADDR   <= ptr;
                            WR_DATA   <= rx_byte;
                            ptr       <= ptr + NREG_LOG2'(1);
                            state     <= WDATA_ACK;
                        end
                    end
                    // bit_cnt counts bits the master has sampled
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr     <= ptr + NREG_LOG2'(1);
                                bit_cnt <= 4'd0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s2) begin
                                state <= IGNORE;
                                BUSY  <= 1'b0;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= RDATA;
                            shreg   <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            bit_cnt <= 4'd0;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master with open-drain SDA and pull-up.
`timescale 1ns/100ps
module tb_i2c_slave_regs;
    localparam int Q = 1000;  // quarter SCL period in ns

    logic       I2C_clk = 1'b0;
    logic       RESET   = 1'b0;
    logic       I2C_SCLK = 1'b1;
    logic       m_sda   = 1'b1;
    wire        sda_bus;
    logic [3:0] RD_ADDR = 4'd0;
    logic [7:0] RD_DATA;
    logic       WR_STROBE;
    logic [3:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       BUSY;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int low_cnt = 0;
    logic [3:0] last_wa = 4'd0, prev_wa = 4'd0;
    logic [7:0] last_wd = 8'd0, prev_wd = 8'd0;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_slave_regs #(.SLAVE_ADDR(7'h20), .NREG_LOG2(4)) dut (
        .I2C_clk(I2C_clk), .RESET(RESET), .I2C_SCLK(I2C_SCLK), .I2C_SDATA(sda_bus),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .WR_STROBE(WR_STROBE),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY)
    );

    always #18.5 I2C_clk = ~I2C_clk;

    // Strobe cycles and DUT-driven-low cycles, sampled on the inactive edge
    always @(negedge I2C_clk) begin
        if (WR_STROBE) begin
            strobe_cnt <= strobe_cnt + 1;
            prev_wa <= last_wa; prev_wd <= last_wd;
            last_wa <= WR_ADDR; last_wd <= WR_DATA;
        end
        if (m_sda && sda_bus === 1'b0) low_cnt <= low_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
        $fatal(1, "timeout");
    end

    task automatic i2c_start;
        m_sda = 1'b1; #(Q);
        I2C_SCLK = 1'b1; #(2*Q);
        m_sda = 1'b0; #(2*Q);
        I2C_SCLK = 1'b0; #(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; #(Q);
        I2C_SCLK = 1'b1; #(2*Q);
        m_sda = 1'b1; #(2*Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; #(Q);
        I2C_SCLK = 1'b1; #(2*Q);
        I2C_SCLK = 1'b0; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        m_sda = 1'b1; #(Q);
        I2C_SCLK = 1'b1; #(Q);
        ack = sda_bus;
        #(Q);
        I2C_SCLK = 1'b0; #(Q);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1; #(Q);
            I2C_SCLK = 1'b1; #(Q);
            d = {d[6:0], sda_bus};
            #(Q);
            I2C_SCLK = 1'b0; #(Q);
        end
        write_bit(mack);
        m_sda = 1'b1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        #(200);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (WR_STROBE !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", WR_STROBE); end
        checks++; if (WR_ADDR !== 4'd0 || WR_DATA !== 8'h00) begin failures++; $display("FAIL reset_wr got=%h/%h exp=0/00", WR_ADDR, WR_DATA); end
        checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
        RESET = 1'b1;
        #(200);
        for (int i = 0; i < 16; i += 5) begin
            RD_ADDR = 4'(i); #1;
            checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", i, RD_DATA); end
        end
    endtask

    task automatic test_write;
        logic a0, a1, a2;
        int s0;
        s0 = strobe_cnt;
        i2c_start;
        send_byte(8'h40, a0);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL write_busy_on got=%b exp=1", BUSY); end
        send_byte(8'h03, a1);
        send_byte(8'hA5, a2);
        i2c_stop;
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL write_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL write_strobes got=%0d exp=1", strobe_cnt - s0); end
        checks++; if (last_wa !== 4'd3 || last_wd !== 8'hA5) begin failures++; $display("FAIL write_wrbus got=%h/%h exp=3/a5", last_wa, last_wd); end
        RD_ADDR = 4'd3; #1;
        checks++; if (RD_DATA !== 8'hA5) begin failures++; $display("FAIL write_rd3 got=%h exp=a5", RD_DATA); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL write_busy_off got=%b exp=0", BUSY); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1;
        int s0, l0;
        s0 = strobe_cnt; l0 = low_cnt;
        i2c_start;
        send_byte(8'h42, a0);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL wrong_busy got=%b exp=0", BUSY); end
        send_byte(8'h03, a1);
        send_byte(8'h77, a1);
        i2c_stop;
        checks++; if (a0 !== 1'b1 || low_cnt - l0 !== 0) begin failures++; $display("FAIL wrong_sda ack=%b lowcycles=%0d exp=1/0", a0, low_cnt - l0); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL wrong_strobes got=%0d exp=0", strobe_cnt - s0); end
        RD_ADDR = 4'd3; #1;
        checks++; if (RD_DATA !== 8'hA5) begin failures++; $display("FAIL wrong_rd3 got=%h exp=a5", RD_DATA); end
    endtask

    task automatic test_burst;
        logic a;
        int s0;
        s0 = strobe_cnt;
        i2c_start;
        send_byte(8'h40, a);
        send_byte(8'h0F, a);
        send_byte(8'h11, a);
        send_byte(8'h22, a);
        i2c_stop;
        checks++; if (strobe_cnt - s0 !== 2) begin failures++; $display("FAIL burst_strobes got=%0d exp=2", strobe_cnt - s0); end
        checks++; if (prev_wa !== 4'd15 || prev_wd !== 8'h11 || last_wa !== 4'd0 || last_wd !== 8'h22) begin
            failures++; $display("FAIL burst_wrbus got=%h/%h,%h/%h exp=f/11,0/22", prev_wa, prev_wd, last_wa, last_wd); end
        RD_ADDR = 4'd15; #1;
        checks++; if (RD_DATA !== 8'h11) begin failures++; $display("FAIL burst_rd15 got=%h exp=11", RD_DATA); end
        RD_ADDR = 4'd0; #1;
        checks++; if (RD_DATA !== 8'h22) begin failures++; $display("FAIL burst_rd0 got=%h exp=22", RD_DATA); end
    endtask

    task automatic test_read;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        i2c_start;
        send_byte(8'h40, a0);
        send_byte(8'h03, a1);
        i2c_start;
        send_byte(8'h41, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL read_acks got=%b exp=000", {a0, a1, a2}); end
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        checks++; if (d0 !== 8'hA5) begin failures++; $display("FAIL read_byte0 got=%h exp=a5", d0); end
        checks++; if (d1 !== 8'h00) begin failures++; $display("FAIL read_byte1 got=%h exp=00", d1); end
        #(Q);
        checks++; if (sda_bus !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL read_nack_release sda=%b busy=%b exp=1/0", sda_bus, BUSY); end
        i2c_stop;
    endtask

    task automatic test_abort_stop;
        logic a;
        int s0;
        s0 = strobe_cnt;
        i2c_start;
        send_byte(8'h40, a);
        send_byte(8'h06, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop;
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL abort_stop_strobes got=%0d exp=0", strobe_cnt - s0); end
        RD_ADDR = 4'd6; #1;
        checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL abort_stop_rd6 got=%h exp=00", RD_DATA); end
        checks++; if (BUSY !== 1'b0 || sda_bus !== 1'b1) begin failures++; $display("FAIL abort_stop_idle busy=%b sda=%b exp=0/1", BUSY, sda_bus); end
    endtask

    task automatic test_abort_reset;
        logic [7:0] addr_byte;
        logic a0, a1, a2;
        int s0;
        addr_byte = 8'h40;
        s0 = strobe_cnt;
        // Reset while the DUT is pulling the address ACK low
        i2c_start;
        for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
        m_sda = 1'b1; #(Q);
        I2C_SCLK = 1'b1; #(Q);
        checks++; if (sda_bus !== 1'b0) begin failures++; $display("FAIL rst_ack_drive got=%b exp=0", sda_bus); end
        RESET = 1'b0; #1;
        checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rst_async_sda got=%b exp=1", sda_bus); end
        #(Q - 1);
        I2C_SCLK = 1'b0; #(Q);
        RESET = 1'b1;
        i2c_stop;
        // Reset in the middle of the sub-address byte
        i2c_start;
        send_byte(8'h40, a0);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        RESET = 1'b0; #1;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", BUSY); end
        #(Q);
        RESET = 1'b1;
        write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        write_bit(1'b1);
        send_byte(8'hEE, a1);
        checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL rst_ignore_ack got=%b exp=1", a1); end
        i2c_stop;
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL rst_strobes got=%0d exp=0", strobe_cnt - s0); end
        RD_ADDR = 4'd3; #1;
        checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL rst_cleared_rd3 got=%h exp=00", RD_DATA); end
        // Next valid write goes through
        i2c_start;
        send_byte(8'h40, a0);
        send_byte(8'h07, a1);
        send_byte(8'h5A, a2);
        i2c_stop;
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rst_next_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (strobe_cnt - s0 !== 1 || last_wa !== 4'd7 || last_wd !== 8'h5A) begin
            failures++; $display("FAIL rst_next_write strobes=%0d wr=%h/%h exp=1 7/5a", strobe_cnt - s0, last_wa, last_wd); end
        RD_ADDR = 4'd7; #1;
        checks++; if (RD_DATA !== 8'h5A) begin failures++; $display("FAIL rst_next_rd7 got=%h exp=5a", RD_DATA); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_wrong_addr;
        test_burst;
        test_read;
        test_abort_stop;
        test_abort_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
